instr_receive: RTL

Receiving end of the instruction-download handshake. On a start pulse it raises a sync request toward the instruction transmitter and captures every word qualified by ack into a local instruction RAM. It stops at the word flagged last and exposes the loaded program to the fetch stage through a registered read port. It reports busy, done and error (timeout or overflow) status.

---
 rtl/instr_receive_if.sv | 28 ++
 rtl/instr_receive.sv | 129 ++++++++++++
 2 files changed

// File: rtl/instr_receive_if.sv
// Download/fetch bundle between the instruction transmitter, fetch stage and instr_receive.
// The slave modport is the receiver side; the master drives requests and reads status.
interface instr_receive_if #(
    parameter int IWIDTH = 32,
    parameter int AWIDTH = 6
);
    logic              r_i_start;
    logic              r_o_syn;
    logic [IWIDTH-1:0] r_i_instr;
    logic              r_i_ack;
    logic              r_i_last;
    logic [AWIDTH-1:0] r_i_raddr;
    logic [IWIDTH-1:0] r_o_rdata;
    logic [AWIDTH:0]   r_o_count;
    logic              r_o_busy;
    logic              r_o_done;
    logic              r_o_err;

    modport slave (
        input  r_i_start, r_i_instr, r_i_ack, r_i_last, r_i_raddr,
        output r_o_syn, r_o_rdata, r_o_count, r_o_busy, r_o_done, r_o_err
    );

    modport master (
        output r_i_start, r_i_instr, r_i_ack, r_i_last, r_i_raddr,
        input  r_o_syn, r_o_rdata, r_o_count, r_o_busy, r_o_done, r_o_err
    );
endinterface

// File: rtl/instr_receive.sv
// Receiving end of the instruction download: requests words, stores acked words in a
// local RAM until the last one, and serves the loaded program through a registered read port.
module instr_receive #(
    parameter int IWIDTH  = 32,
    parameter int DEPTH   = 64,
    parameter int AWIDTH  = 6,
    parameter int TIMEOUT = 16
) (
    input  logic            t_clk,
    input  logic            t_rst,
    instr_receive_if.slave  bus
);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [AWIDTH:0] FULL     = (AWIDTH + 1)'(DEPTH);
    localparam logic [TW-1:0]   TMO_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        LOAD = 3'd2,
        DONE = 3'd3,
        ERR  = 3'd4
    } state_t;

    state_t            state_q;
    logic              syn_q;
    logic              busy_q;
    logic              done_q;
    logic              err_q;
    logic [AWIDTH:0]   count_q;
    logic [AWIDTH:0]   count_d;
    logic [TW-1:0]     timeout_q;
    logic [TW-1:0]     timeout_d;
    logic [IWIDTH-1:0] rdata_q;
    logic [IWIDTH-1:0] mem [DEPTH];

    logic receiving;
    logic overflow;
    logic wrEn;

    assign receiving = (state_q == REQ) || (state_q == LOAD);
    assign overflow  = (count_q == FULL);
    assign wrEn      = receiving && bus.r_i_ack && !overflow;
    assign count_d   = count_q + (AWIDTH + 1)'(1);
    assign timeout_d = timeout_q + TW'(1);

    // REQ and LOAD share the word handling; they differ only in which words they can see.
    always_ff @(posedge t_clk or negedge t_rst) begin
        if (!t_rst) begin
            state_q   <= IDLE;
            syn_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            count_q   <= '0;
            timeout_q <= '0;
        end else begin
            case (state_q)
                IDLE, DONE, ERR: begin
                    if (bus.r_i_start) begin
                        state_q   <= REQ;
                        syn_q     <= 1'b1;
                        busy_q    <= 1'b1;
                        done_q    <= 1'b0;
                        err_q     <= 1'b0;
                        count_q   <= '0;
                        timeout_q <= '0;
                    end
                end
                REQ, LOAD: begin
                    if (bus.r_i_ack) begin
                        if (overflow) begin
                            state_q <= ERR;
                            syn_q   <= 1'b0;
                            busy_q  <= 1'b0;
                            err_q   <= 1'b1;
                        end else begin
                            count_q   <= count_d;
                            timeout_q <= '0;
                            if (bus.r_i_last) begin
                                state_q <= DONE;
                                syn_q   <= 1'b0;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                            end else begin
                                state_q <= LOAD;
                            end
                        end
                    end else if (timeout_q == TMO_LAST) begin
                        state_q   <= ERR;
                        syn_q     <= 1'b0;
                        busy_q    <= 1'b0;
                        err_q     <= 1'b1;
                        timeout_q <= timeout_d;
                    end else begin
                        timeout_q <= timeout_d;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    syn_q   <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // RAM is never reset so a reset keeps the last program; writes stop as soon as state leaves REQ/LOAD.
    always_ff @(posedge t_clk) begin
        if (wrEn) begin
            mem[count_q[AWIDTH-1:0]] <= bus.r_i_instr;
        end
    end

    always_ff @(posedge t_clk or negedge t_rst) begin
        if (!t_rst) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= mem[bus.r_i_raddr];
        end
    end

    assign bus.r_o_syn   = syn_q;
    assign bus.r_o_busy  = busy_q;
    assign bus.r_o_done  = done_q;
    assign bus.r_o_err   = err_q;
    assign bus.r_o_count = count_q;
    assign bus.r_o_rdata = rdata_q;
endmodule
